// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, bubble encoding and the
// buffered-response record.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } hold_entry_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer between the memory response and the IF/ID register.
// Clear wins over fill; a fill in the same cycle as a drain leaves the buffer full.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_fill,
    input  logic        i_drain,
    input  logic        i_clear,
    input  hold_entry_t i_entry,
    output hold_entry_t o_entry,
    output logic        o_full
);

    hold_entry_t r_entry;
    logic        r_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_fill) begin
            r_full  <= 1'b1;
            r_entry <= i_entry;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_entry = r_entry;
    assign o_full  = r_full;

endmodule

// File: rtl/fetch_unit.sv
// IF stage and IF/ID register: one outstanding request to a variable-latency instruction
// memory, a one-entry response buffer, and redirect handling that drops wrong-path responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchWaitF
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pcf;
    logic [31:0]  r_req_pc;
    logic [31:0]  r_instr_d;
    logic [31:0]  r_pc_d;
    logic [31:0]  r_pcplus4_d;
    logic         r_valid_d;

    hold_entry_t  w_hold_entry;
    hold_entry_t  w_fill_entry;
    logic         w_hold_full;
    logic         w_hold_fill;
    logic         w_hold_drain;
    logic         w_req_fire;

    // Flush consumes a buffered entry just like a normal IF/ID load does.
    assign w_hold_drain = w_hold_full && (PCSrcE || FlushD || !StallD);
    assign w_hold_fill  = (r_state == S_WAIT) && imem_rsp_valid && !PCSrcE;
    assign w_fill_entry = '{instr: imem_rsp_data, pc: r_req_pc};

    assign imem_req_valid = rst_n && (r_state == S_REQ) && !StallF
                            && (!w_hold_full || w_hold_drain);
    assign imem_req_addr  = r_pcf;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign FetchWaitF     = rst_n && !PCSrcE && !FlushD && !StallD && !w_hold_full;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_fill  (w_hold_fill),
        .i_drain (w_hold_drain),
        .i_clear (PCSrcE),
        .i_entry (w_fill_entry),
        .o_entry (w_hold_entry),
        .o_full  (w_hold_full)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) begin
                    w_state_next = PCSrcE ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_next = S_REQ;
                end else if (PCSrcE) begin
                    w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_REQ;
        endcase
    end

    // PCF only advances once the response for it is in hand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_REQ;
            r_pcf    <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            if (PCSrcE) begin
                r_pcf <= PCTargetE;
            end else if (w_hold_fill) begin
                r_pcf <= r_req_pc + 32'd4;
            end
            if (w_req_fire) begin
                r_req_pc <= r_pcf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= 32'd0;
            r_pcplus4_d <= 32'd0;
            r_valid_d   <= 1'b0;
        end else if (PCSrcE || FlushD) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (w_hold_full) begin
                r_instr_d   <= w_hold_entry.instr;
                r_pc_d      <= w_hold_entry.pc;
                r_pcplus4_d <= w_hold_entry.pc + 32'd4;
                r_valid_d   <= 1'b1;
            end else begin
                r_instr_d <= NOP_INSTR;
                r_valid_d <= 1'b0;
            end
        end
    end

    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pcplus4_d;
    assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests, the expected stream is
// program-order PCs restarted at every redirect, and a monitor checks each IF/ID load.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchWaitF;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD),
        .FetchWaitF     (FetchWaitF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    pend_t       pend_q[$];

    bit          c_stallf, c_stalld, c_flushd, c_pcsrc, c_redir_on_rsp, c_flush_drop, c_ready;
    logic [31:0] c_target;
    int unsigned c_lat;
    int unsigned hs_cnt = 0, rsp_cnt = 0, deliv_cnt = 0;
    logic [31:0] last_req_addr;
    bit          fw_pre = 1'b0;
    bit          armed  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        next_pc = pc;
        topup();
    endtask

    task automatic quiet();
        c_stallf = 0; c_stalld = 0; c_flushd = 0; c_pcsrc = 0;
        c_redir_on_rsp = 0; c_flush_drop = 0; c_ready = 1;
    endtask

    // One clock: drive at the falling edge, account for handshakes just before the rising edge.
    task automatic step();
        bit rsp_now, redir_now;
        @(negedge clk);
        armed = 1'b1;
        cyc++;
        rsp_now   = pend_q.size() > 0 && pend_q[0].due <= cyc;
        redir_now = c_pcsrc || (c_redir_on_rsp && rsp_now);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(pend_q[0].addr) : $urandom;
        StallF         = c_stallf;
        StallD         = c_stalld;
        FlushD         = c_flushd;
        PCSrcE         = redir_now;
        PCTargetE      = redir_now ? c_target : $urandom;
        imem_req_ready = c_ready;
        #4;
        fw_pre = FetchWaitF;
        if (rsp_now) begin
            void'(pend_q.pop_front());
            rsp_cnt++;
        end
        if (imem_req_valid && imem_req_ready) begin
            pend_q.push_back('{imem_req_addr, cyc + c_lat});
            hs_cnt++;
            last_req_addr = imem_req_addr;
        end
        if (rst_n && redir_now) begin
            restart_stream(c_target);
            c_redir_on_rsp = 0;
        end else if (rst_n && FlushD && c_flush_drop) begin
            void'(exp_q.pop_front());
        end
        topup();
    endtask

    task automatic wait_hs(input string name);
        int unsigned start = hs_cnt;
        for (int i = 0; i < 40 && hs_cnt == start; i++) step();
        check(name, 32'(hs_cnt != start), 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        int unsigned start = rsp_cnt;
        for (int i = 0; i < 40 && rsp_cnt == start; i++) step();
        check(name, 32'(rsp_cnt != start), 32'd1);
    endtask

    // Monitor: every rising edge, decide from the applied controls what IF/ID must now hold.
    initial begin
        logic [31:0] p_instr, p_pcd, p_pc4, e;
        logic        p_valid;
        bit          m_rst, m_bub, m_stall, m_fw, m_armed;
        p_instr = NOP; p_pcd = 0; p_pc4 = 0; p_valid = 0;
        forever begin
            @(posedge clk);
            m_rst = rst_n; m_bub = PCSrcE || FlushD; m_stall = StallD;
            m_fw = fw_pre; m_armed = armed;
            #1;
            if (m_armed && m_rst && rst_n) begin
                if (m_bub) begin
                    check("bubble_valid", 32'(ValidD), 32'd0);
                    check("bubble_instr", InstrD, NOP);
                    check("bubble_pcd_hold", PCD, p_pcd);
                end else if (m_stall) begin
                    check("stall_instr", InstrD, p_instr);
                    check("stall_pcd", PCD, p_pcd);
                    check("stall_pc4", PCPlus4D, p_pc4);
                    check("stall_valid", 32'(ValidD), 32'(p_valid));
                end else if (ValidD) begin
                    check("fetchwait_low", 32'(m_fw), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_delivery", PCD, 32'hDEAD_BEEF);
                    end else begin
                        e = exp_q.pop_front();
                        check("deliv_pcd", PCD, e);
                        check("deliv_instr", InstrD, mem_word(e));
                        check("deliv_pc4", PCPlus4D, e + 32'd4);
                        deliv_cnt++;
                    end
                end else begin
                    check("fetchwait_high", 32'(m_fw), 32'd1);
                    check("wait_instr", InstrD, NOP);
                end
            end
            p_instr = InstrD; p_pcd = PCD; p_pc4 = PCPlus4D; p_valid = ValidD;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0;
        int unsigned pf, pd, pr;
        quiet();
        c_lat = 1; c_target = 0;
        rst_n = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        restart_stream(32'h0);
        #12;
        check("rst_valid", 32'(ValidD), 32'd0);
        check("rst_instr", InstrD, NOP);
        check("rst_pcd", PCD, 32'd0);
        check("rst_pc4", PCPlus4D, 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        #10 rst_n = 1;

        // Back-to-back fetch, 1-cycle memory: one instruction every two cycles.
        repeat (4) step();
        d0 = deliv_cnt;
        repeat (20) step();
        check("t1_rate", deliv_cnt - d0, 32'd10);

        // Response arrives under StallD: buffer full blocks further requests.
        c_lat = 3;
        wait_hs("t2_wait_hs");
        c_stalld = 1;
        wait_rsp("t2_wait_rsp");
        repeat (3) begin
            step();
            check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        end
        c_stalld = 0;
        step();
        check("t2_req_on_drain", 32'(imem_req_valid), 32'd1);
        repeat (6) step();

        // FlushD with a full buffer drops the buffered instruction.
        wait_hs("t4_wait_hs");
        c_stalld = 1;
        wait_rsp("t4_wait_rsp");
        step();
        check("t4_req_blocked", 32'(imem_req_valid), 32'd0);
        c_flushd = 1; c_flush_drop = 1;
        step();
        check("t4_req_after_flush", 32'(imem_req_valid), 32'd1);
        quiet();
        repeat (8) step();

        // Redirect while waiting: in-flight response is discarded.
        wait_hs("t3_wait_hs");
        step();
        c_pcsrc = 1; c_target = 32'h0000_0100;
        step();
        c_pcsrc = 0;
        wait_hs("t3_wait_redir_hs");
        check("t3_req_addr", last_req_addr, 32'h0000_0100);
        repeat (8) step();

        // Redirect coincident with the response while decode is stalled.
        c_lat = 2;
        wait_hs("t5_wait_hs");
        c_stalld = 1; c_redir_on_rsp = 1; c_target = 32'hFFFF_FFF8;
        wait_rsp("t5_wait_rsp");
        wait_hs("t5_wait_redir_hs");
        check("t5_req_addr", last_req_addr, 32'hFFFF_FFF8);
        quiet();
        repeat (10) step();

        // Reset pulse during an outstanding request; the late response must be ignored.
        c_lat = 5;
        wait_hs("t6_wait_hs");
        step();
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("t6_rst_valid", 32'(ValidD), 32'd0);
        check("t6_rst_instr", InstrD, NOP);
        check("t6_rst_pcd", PCD, 32'd0);
        check("t6_rst_pc4", PCPlus4D, 32'd0);
        check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        restart_stream(32'h0);
        c_stallf = 1;
        step();
        @(posedge clk);
        #3 rst_n = 1;
        for (int i = 0; i < 10 && pend_q.size() > 0; i++) begin
            step();
            check("t6_stallf_no_req", 32'(imem_req_valid), 32'd0);
        end
        check("t6_late_rsp_sent", 32'(pend_q.size()), 32'd0);
        c_stallf = 0;
        wait_hs("t6_wait_hs_after");
        check("t6_req_addr", last_req_addr, 32'h0);
        repeat (10) step();

        // Randomized phases with increasing stall and backpressure pressure.
        for (int ph = 0; ph < 6; ph++) begin
            pf = 32'(ph) * 6;
            pd = 32'(ph) * 6;
            pr = 100 - 32'(ph) * 8;
            for (int i = 0; i < 300; i++) begin
                c_stallf = $urandom_range(99) < pf;
                c_stalld = $urandom_range(99) < pd;
                c_pcsrc  = $urandom_range(99) < 3;
                c_flushd = c_pcsrc && ($urandom_range(1) == 1);
                c_ready  = $urandom_range(99) < pr;
                c_lat    = $urandom_range(4, 1);
                case ($urandom_range(3))
                    0: c_target = 32'hFFFF_FFF8;
                    1: c_target = 32'h0000_0100;
                    default: c_target = $urandom & 32'hFFFF_FFFC;
                endcase
                step();
            end
        end
        quiet();
        repeat (20) step();
        check("liveness", 32'(deliv_cnt >= 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
